imem_bank: RTL and testbench
============================

# imem_bank

Parametrised, loadable instruction memory for the pipelined MIPS core's fetch stage. It replaces the fixed reset-time program image with three features: a clear-on-reset sequencer, a streaming load port with a valid/ready handshake, and a registered fetch port with stall hold and fault flagging. Fetch sits between the PC register and the IF/ID pipeline register. The load port is driven by the testbench or a boot loader.

## Interface
- DATA_W, 32, instruction word width
- DEPTH, 1024, number of words (power of two, ≥ 4)
- ADDR_W, 32, fetch address width (byte address)
- IDX_W, $clog2(DEPTH), word index width (derived)
- NOP, 0, word returned on a fault or while busy

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_en  in  1  fetch request this cycle
- fetch_addr  in  ADDR_W  byte address of the instruction
- stall  in  1  hold fetch outputs (pipeline stall)
- instr  out  DATA_W  fetched word
- instr_valid  out  1  instr holds a completed fetch
- fault  out  1  the fetch shown on instr was misaligned or out of range
- load_start  in  1  pulse: begin a load at load_base
- load_base  in  IDX_W  first word index to write
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  word to write
- load_last  in  1  the current beat is the final word
- load_ready  out  1  the memory accepts a load beat this cycle
- busy  out  1  the memory is clearing or loading; fetch is disabled
- load_count  out  IDX_W+1  words written by the current or last load
- overflow  out  1  sticky flag: the load ran past DEPTH-1

## Operation
- FSM states are CLEAR, READY and LOAD. Reset enters CLEAR.
- CLEAR:
  - A clear pointer starts at 0 and writes NOP to one word per cycle.
  - After writing word DEPTH-1, the FSM moves to READY.
  - busy=1 throughout.
- READY:
  - busy=0, load_ready=0.
  - On load_start=1:
    - The write pointer loads load_base.
    - load_count clears to 0 and overflow clears to 0.
    - The FSM moves to LOAD.
- LOAD:
  - busy=1 and load_ready=1.
  - A beat is accepted when load_valid && load_ready. On each accepted beat:
    - mem[ptr] is written with load_data.
    - ptr increments and load_count increments.
  - The FSM returns to READY on an accepted beat that has load_last=1.
  - The FSM also returns to READY on an accepted beat written at ptr==DEPTH-1 with load_last=0. In that case overflow is set. The pointer never wraps.
- load_start is ignored outside READY.
- Fetch, when not busy and fetch_en=1 and stall=0:
  - The word index is fetch_addr[IDX_W+1:2].
  - The fetch is misaligned if fetch_addr[1:0]≠0.
  - The fetch is out of range if any bit of fetch_addr[ADDR_W-1:IDX_W+2] is set.
  - On either fault, the next instr=NOP and fault=1. Otherwise instr=mem[index] and fault=0.
  - instr_valid=1 on the next cycle in both cases.
- stall=1: instr, instr_valid and fault hold their values, and fetch_en is ignored.
- When busy, or when fetch_en=0 with stall=0, the next cycle has instr_valid=0, instr=NOP and fault=0.

## Timing
- Reset values:
  - instr=NOP, instr_valid=0, fault=0.
  - busy=1, load_ready=0.
  - load_count=0, overflow=0.
  - FSM=CLEAR, clear pointer=0.
- Clear takes exactly DEPTH cycles after rst is released. busy falls on the following edge.
- Fetch latency is 1 cycle (registered read). The request at edge N appears on instr after edge N+1.
- load_start and fetch_en in the same READY cycle:
  - The fetch is served from the pre-load contents.
  - busy=1 from the next cycle.
  - A fetch_en in the LOAD cycles that follow returns instr_valid=0.
- Load throughput is one word per cycle. load_ready is combinational from the state only (state==LOAD).
- The first beat can be accepted in the cycle after load_start.
- If rst asserts mid-load or mid-clear:
  - All outputs go immediately to their reset values.
  - The FSM restarts at CLEAR, and contents are re-cleared.
- Simultaneous stall=1 and busy rising: the held outputs persist until stall=0, then follow the busy rule.

## Test plan
- Reset with DEPTH=16: busy=1 for 16 cycles after rst falls. Then fetch of 0x0, 0x3C → instr=0x00000000, instr_valid=1, fault=0.
- Load at load_base=2 with 3 beats (0x8C0A0020, 0x8C0B0021, last 0x1000FFFC):
  - load_count=3, overflow=0.
  - Fetch 0x8 → 0x8C0A0020 and fetch 0x10 → 0x1000FFFC, each one cycle after the request.
- Load gaps and stall:
  - Toggle load_valid every other cycle: only the accepted beats are written.
  - Assert stall=1 during a fetch stream: instr holds for 3 cycles, then resumes at the next address.
- Faults: fetch 0x6 → fault=1, instr=NOP. Fetch 0x40 with DEPTH=16 → fault=1. Fetch 0x3C → fault=0.
- Overflow: DEPTH=16, load_base=14, 4 beats with no load_last → 2 words written, overflow=1, READY reached, load_count=2.
- Reset mid-load after 2 beats: outputs reset asynchronously, the clear repeats, and the previously loaded words read back as 0.

Source files
------------

// File: rtl/imem_bank.sv
`default_nettype none
// ============================================================================
// Module   : imem_bank
// Brief    : Loadable instruction memory with a clear-on-reset sequencer,
//            a streaming valid/ready load port and a registered fetch port.
// Revision : 1.0
// ============================================================================
module imem_bank #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 1024,
    parameter int                ADDR_W = 32,
    parameter int                IDX_W  = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    input  logic              load_start,
    input  logic [IDX_W-1:0]  load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              busy,
    output logic [IDX_W:0]    load_count,
    output logic              overflow
);

    localparam logic [1:0]       S_CLEAR  = 2'd0;
    localparam logic [1:0]       S_READY  = 2'd1;
    localparam logic [1:0]       S_LOAD   = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_busy;
    logic              w_beat;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_misalign;
    logic              w_oor;
    logic              w_fault;

    assign w_busy     = (state_q != S_READY);
    assign w_beat     = (state_q == S_LOAD) && load_valid;
    assign w_idx      = fetch_addr[IDX_W+1:2];
    assign w_misalign = |fetch_addr[1:0];
    assign w_fault    = w_misalign | w_oor;

    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_check
            assign w_oor = |fetch_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_range_check
            assign w_oor = 1'b0;
        end
    endgenerate

    // One pointer serves both the clear sweep and the load stream.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (load_start) begin
                    ptr_d   = load_base;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    count_d = count_q + 1'b1;
                    if (ptr_q != LAST_IDX) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (load_last) begin
                        state_d = S_READY;
                    end else if (ptr_q == LAST_IDX) begin
                        ovf_d   = 1'b1;
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (!stall) begin
            if (!w_busy && fetch_en) begin
                valid_d = 1'b1;
                fault_d = w_fault;
                instr_d = w_fault ? NOP : mem_q[w_idx];
            end else begin
                valid_d = 1'b0;
                fault_d = 1'b0;
                instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Storage has no reset; the clear sweep initialises it after every reset.
    assign w_we    = (state_q == S_CLEAR) || w_beat;
    assign w_wdata = (state_q == S_CLEAR) ? NOP : load_data;

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[ptr_q] <= w_wdata;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign busy        = w_busy;
    assign load_ready  = (state_q == S_LOAD);
    assign load_count  = count_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_bank
// Brief    : Directed and randomized checks of imem_bank against a
//            word-array reference model.
// Revision : 1.0
// ============================================================================
module tb_imem_bank;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              stall = 1'b0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fault;
    logic              load_start = 1'b0;
    logic [IDX_W-1:0]  load_base = '0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              busy;
    logic [IDX_W:0]    load_count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    imem_bank #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .fault      (fault),
        .load_start (load_start),
        .load_base  (load_base),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .busy       (busy),
        .load_count (load_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain word array plus a few counters.
    logic [31:0] model_mem [DEPTH];
    int          clear_left = DEPTH;
    bit          loading    = 1'b0;
    int          m_ptr      = 0;
    int          m_cnt      = 0;
    bit          m_ovf      = 1'b0;
    logic [31:0] m_instr    = '0;
    bit          m_valid    = 1'b0;
    bit          m_fault    = 1'b0;
    bit          bad;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left = DEPTH;
            loading    = 1'b0;
            m_cnt      = 0;
            m_ovf      = 1'b0;
            m_instr    = '0;
            m_valid    = 1'b0;
            m_fault    = 1'b0;
        end else begin
            if (!stall) begin
                if (clear_left == 0 && !loading && fetch_en) begin
                    bad     = (fetch_addr % 4 != 0) || (fetch_addr >= DEPTH * 4);
                    m_instr = bad ? 32'h0 : model_mem[fetch_addr / 4];
                    m_valid = 1'b1;
                    m_fault = bad;
                end else begin
                    m_instr = '0;
                    m_valid = 1'b0;
                    m_fault = 1'b0;
                end
            end
            if (clear_left > 0) begin
                model_mem[DEPTH - clear_left] = '0;
                clear_left--;
            end else if (loading) begin
                if (load_valid) begin
                    model_mem[m_ptr] = load_data;
                    m_cnt++;
                    if (load_last) loading = 1'b0;
                    else if (m_ptr == DEPTH - 1) begin
                        m_ovf   = 1'b1;
                        loading = 1'b0;
                    end
                    m_ptr++;
                end
            end else if (load_start) begin
                m_ptr   = int'(load_base);
                m_cnt   = 0;
                m_ovf   = 1'b0;
                loading = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("instr",       instr,              m_instr);
        check("instr_valid", 32'(instr_valid),   32'(m_valid));
        check("fault",       32'(fault),         32'(m_fault));
        check("busy",        32'(busy),          32'(clear_left > 0 || loading));
        check("load_ready",  32'(load_ready),    32'(loading));
        check("load_count",  32'(load_count),    32'(m_cnt));
        check("overflow",    32'(overflow),      32'(m_ovf));
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        cycle();
        fetch_en   = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy && n < 40) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] beats [3];
        beats[0] = 32'h8C0A0020;
        beats[1] = 32'h8C0B0021;
        beats[2] = 32'h1000FFFC;

        cycle();
        cycle();
        check("rst_busy",  32'(busy), 32'd1);
        check("rst_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        wait_clear(n);
        check("clear_cycles", n, 32'd16);

        fetch(32'h0);
        check("fetch0", instr, 32'h0);
        check("fetch0_valid", 32'(instr_valid), 32'd1);
        fetch(32'h3C);
        check("fetch3c_fault", 32'(fault), 32'd0);

        load_start = 1'b1;
        load_base  = 4'd2;
        cycle();
        load_start = 1'b0;
        check("load_ready", 32'(load_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = beats[i];
            load_last  = (i == 2);
            cycle();
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (i == 0) cycle();
        end
        check("load_count3", 32'(load_count), 32'd3);
        check("load_ovf0",   32'(overflow),   32'd0);
        check("load_done",   32'(busy),       32'd0);
        fetch(32'h8);
        check("fetch8", instr, 32'h8C0A0020);
        fetch(32'h10);
        check("fetch10", instr, 32'h1000FFFC);

        fetch(32'h6);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_instr", instr, 32'h0);
        fetch(32'h40);
        check("oor_fault", 32'(fault), 32'd1);
        fetch(32'h3C);
        check("inr_fault", 32'(fault), 32'd0);

        fetch(32'h8);
        fetch_en   = 1'b1;
        fetch_addr = 32'hC;
        stall      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_hold", instr, 32'h8C0A0020);
        end
        stall = 1'b0;
        cycle();
        fetch_en = 1'b0;
        check("stall_resume", instr, 32'h8C0B0021);

        load_start = 1'b1;
        load_base  = 4'd14;
        cycle();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA5A50000 + i;
            cycle();
        end
        load_valid = 1'b0;
        check("ovf_count", 32'(load_count), 32'd2);
        check("ovf_flag",  32'(overflow),   32'd1);
        check("ovf_ready", 32'(busy),       32'd0);
        fetch(32'h3C);
        check("ovf_word15", instr, 32'hA5A50001);

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      fetch_addr = $urandom;
            else if (r == 1) fetch_addr = $urandom_range(0, 63);
            else             fetch_addr = $urandom_range(0, 15) * 4;
            fetch_en   = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            load_start = ($urandom_range(0, 19) == 0);
            load_base  = 4'($urandom_range(0, 15));
            load_valid = $urandom_range(0, 1) == 1;
            load_data  = $urandom;
            load_last  = ($urandom_range(0, 6) == 0);
            cycle();
        end
        fetch_en   = 1'b0;
        stall      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        cycle();
        while (busy && n < 100) begin
            cycle();
            n++;
        end

        load_start = 1'b1;
        load_base  = 4'd0;
        cycle();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hDEAD0000 + i;
            cycle();
        end
        load_valid = 1'b0;
        check("pre_rst_count", 32'(load_count), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",  32'(busy),       32'd1);
        check("arst_ready", 32'(load_ready), 32'd0);
        check("arst_count", 32'(load_count), 32'd0);
        cycle();
        rst = 1'b0;
        wait_clear(n);
        check("reclear_cycles", n, 32'd16);
        fetch(32'h0);
        check("reclear_w0", instr, 32'h0);
        fetch(32'h4);
        check("reclear_w1", instr, 32'h0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
